// File: rtl/eyeriss_csc_pkg.sv
// Shared constants and state encoding for the CSC address encoders.
package eyeriss_csc_pkg;

    localparam int unsigned DATA_WIDTH           = 8;
    localparam int unsigned ADDR_WIDTH           = 8;
    localparam int unsigned IACT_ADDR_SPAD_DEPTH = 12;
    localparam int unsigned MAX_COLS             = IACT_ADDR_SPAD_DEPTH - 1;
    localparam int unsigned END_SIGN             = 0;
    localparam int unsigned LEAD_SKIP_WIDTH      = 4;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TERM = 1'b1
    } csc_state_e;

endpackage

// File: rtl/iact_addr_csc_encoder_if.sv
// Dense iact input stream plus spad address write port.
// slave  : encoder view (consumes the stream, drives the spad port).
// master : environment view (router drives the stream, spad returns ready).
interface iact_addr_csc_encoder_if #(
    parameter int unsigned DATA_WIDTH = eyeriss_csc_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = eyeriss_csc_pkg::ADDR_WIDTH
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_col_end;
    logic                  in_mat_end;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic                  addr_valid;
    logic                  addr_ready;
    logic                  write_en;

    modport slave (
        input  in_data, in_valid, in_col_end, in_mat_end, addr_ready,
        output in_ready, addr_out, addr_valid, write_en
    );

    modport master (
        output in_data, in_valid, in_col_end, in_mat_end, addr_ready,
        input  in_ready, addr_out, addr_valid, write_en
    );
endinterface

// File: rtl/csc_out_reg.sv
// One-entry valid/ready holding register. The caller only loads when free.
module csc_out_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             free,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    // Free when empty or when the held entry handshakes this cycle.
    always_comb begin
        free = !out_valid || out_ready;
    end

    // Hold the entry until it handshakes; a load in the same cycle wins.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/iact_addr_csc_encoder.sv
// Turns a dense column-major iact stream into cumulative-nonzero column
// end-pointers for the iact address spad, followed by the 0 end sign.
module iact_addr_csc_encoder #(
    parameter int unsigned DATA_WIDTH = eyeriss_csc_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = eyeriss_csc_pkg::ADDR_WIDTH,
    parameter int unsigned MAX_COLS   = eyeriss_csc_pkg::MAX_COLS
) (
    input  logic                          clock,
    input  logic                          reset,
    iact_addr_csc_encoder_if.slave        bus,
    output logic [3:0]                    lead_skip,
    output logic                          done,
    output logic                          err
);
    import eyeriss_csc_pkg::*;

    localparam int unsigned COL_W = $clog2(MAX_COLS + 1);
    localparam logic [COL_W-1:0]      MAX_COL_IDX = COL_W'(MAX_COLS);
    localparam logic [ADDR_WIDTH-1:0] END_ADDR    = ADDR_WIDTH'(END_SIGN);

    csc_state_e state, state_next;

    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_next;
    logic [COL_W-1:0]      col_idx;
    logic                  mat_started;

    logic                  in_ready;
    logic                  beat_acc;
    logic                  nz;
    logic                  sat;
    logic                  col_end_acc;
    logic                  col_empty;
    logic                  col_drop;
    logic                  col_load;
    logic                  term_in_reg;
    logic                  term_hs;
    logic                  term_load;
    logic                  reg_free;
    logic                  reg_load;
    logic [ADDR_WIDTH-1:0] load_data;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  valid_q;

    csc_out_reg #(.WIDTH(ADDR_WIDTH)) u_out_reg (
        .clock     (clock),
        .reset     (reset),
        .load      (reg_load),
        .load_data (load_data),
        .free      (reg_free),
        .out_data  (addr_q),
        .out_valid (valid_q),
        .out_ready (bus.addr_ready)
    );

    assign bus.in_ready   = in_ready;
    assign bus.addr_out   = addr_q;
    assign bus.addr_valid = valid_q;
    assign bus.write_en   = valid_q;

    // Beat acceptance, column classification, terminator control, next state.
    always_comb begin
        in_ready    = reset && (state == ST_RUN) && reg_free;
        beat_acc    = bus.in_valid && in_ready;
        nz          = (bus.in_data != '0);
        sat         = beat_acc && nz && (cnt == '1);
        cnt_next    = cnt + ADDR_WIDTH'(nz && (cnt != '1));
        col_end_acc = beat_acc && bus.in_col_end;
        col_empty   = col_end_acc && (cnt_next == '0);
        col_drop    = col_end_acc && !col_empty && (col_idx == MAX_COL_IDX);
        col_load    = col_end_acc && !col_empty && !col_drop;
        // Column addresses are never 0, so a held 0 while in TERM is the terminator.
        term_in_reg = (state == ST_TERM) && valid_q && (addr_q == END_ADDR);
        term_hs     = term_in_reg && bus.addr_ready;
        term_load   = (state == ST_TERM) && reg_free && !term_in_reg;
        reg_load    = col_load || term_load;
        load_data   = col_load ? cnt_next : END_ADDR;
        state_next  = state;
        case (state)
            ST_RUN:  if (col_end_acc && bus.in_mat_end) state_next = ST_TERM;
            ST_TERM: if (term_hs) state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    // State register, counters, leading-skip tracking and status flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= ST_RUN;
            cnt         <= '0;
            col_idx     <= '0;
            mat_started <= 1'b0;
            lead_skip   <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state <= state_next;
            done  <= term_hs;
            if (sat || col_drop) err <= 1'b1;
            if (term_hs) begin
                cnt         <= '0;
                col_idx     <= '0;
                mat_started <= 1'b0;
            end else if (beat_acc) begin
                cnt <= cnt_next;
                if (col_end_acc) mat_started <= 1'b1;
                if (col_load) col_idx <= col_idx + 1'b1;
            end
            // lead_skip of the previous matrix survives until this matrix's first column end.
            if (col_end_acc) begin
                if (!mat_started) lead_skip <= col_empty ? 4'd1 : 4'd0;
                else if (col_empty && lead_skip != '1) lead_skip <= lead_skip + 1'b1;
            end
        end
    end

endmodule

// File: doc/iact_addr_csc_encoder.md
Name: iact_addr_csc_encoder

Overview:
- Transmitter side of the iact address spad write interface.
- Consumes a dense, column-major stream of iact values from the GLB-side router port.
- For each column, counts nonzeros and emits the running end-pointer (cumulative nonzero count). After the last column it emits the 0 end sign.
- Drives the spad's data_in / data_in_valid / write_en. The spad's data_in_ready is returned on addr_ready.

Parameters:
- DATA_WIDTH, 8, width of an incoming iact value.
- ADDR_WIDTH, 8, width of an emitted address; cumulative count range 0..255.
- MAX_COLS, 11, max address entries per matrix. Spad depth is 12: 11 addresses plus the terminator.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-low; registers clear on rising clock edge while reset==0.
- in_data  in  DATA_WIDTH  dense iact value.
- in_valid  in  1  in_data/in_col_end/in_mat_end valid.
- in_ready  out  1  encoder accepts beat.
- in_col_end  in  1  beat is last of its column.
- in_mat_end  in  1  beat is last of matrix; only meaningful with in_col_end=1.
- addr_out  out  ADDR_WIDTH  address to spad data_in.
- addr_valid  out  1  to spad data_in_valid.
- addr_ready  in  1  from spad data_in_ready.
- write_en  out  1  to spad write_en; equals addr_valid.
- lead_skip  out  4  number of suppressed leading empty columns of the current/last matrix.
- done  out  1  one-cycle pulse when the terminator handshakes.
- err  out  1  sticky: count saturation or column overflow; cleared only by reset.

Behaviour:
- Reset values (reset==0): state=RUN, all outputs 0, cnt=0, col_idx=0, in_ready=0 in the reset cycle.
- States:
  - RUN: accepts input.
  - TERM: terminator pending.
- Single output holding register (addr_out, addr_valid). Output handshake: addr_valid & addr_ready.
  - addr_valid stays high and addr_out stays stable until handshake.
  - write_en = addr_valid.
- in_ready = (state==RUN) & (!addr_valid | addr_ready). Input beat accepted when in_valid & in_ready.
- On an accepted beat:
  - nz = (in_data != 0).
  - cnt_next = cnt + nz.
  - If cnt==255 and nz: cnt holds at 255 and err sets.
- On an accepted beat with in_col_end=1:
  - cnt_next != 0: load addr_out=cnt_next, addr_valid=1, col_idx+1.
  - cnt_next == 0 (leading empty column; 0 would read as end sign): emit nothing, lead_skip+1, saturating at 15.
  - col_idx==MAX_COLS: drop the address, set err, continue counting.
- Accepted beat with in_col_end & in_mat_end → state TERM after the column update.
- TERM:
  - When the holding register is free (empty, or handshaking this cycle), load addr_out=0, addr_valid=1.
  - On its handshake: pulse done, cnt=0, col_idx=0, state RUN.
  - lead_skip holds until the first col_end of the next matrix.
- Latency: address visible the cycle after the col_end beat is accepted. With addr_ready=1 continuously, throughput is 1 beat/cycle.
- Back-to-back: a column address handshaking and a new beat accepted in the same cycle is legal; the register reloads without a bubble.
- in_mat_end without in_col_end: treated as ordinary beat.
- All-empty matrix: only the terminator is emitted; lead_skip = column count.
- Reset mid-matrix: pending address and terminator discarded; addr_valid=0 next cycle.

Decomposition:
- Shared package `eyeriss_csc_pkg`: ADDR_WIDTH, DATA_WIDTH, IACT_ADDR_SPAD_DEPTH=12, END_SIGN=0, state encoding.
- Optional sub-module `csc_out_reg`: one-entry valid/ready holding register, reusable for the weight-address encoder.

Test Plan:
- Columns [3,0,5 | 0,0 | 7] with mat_end on 7, addr_ready=1 → addr_out 2, 2, 3, then 0. done pulses once, lead_skip=0, err=0.
- Leading empty columns [0,0 | 0 | 4] → addr_out 1, then 0. lead_skip=2.
- Same stream as case 1 with addr_ready low 3 cycles at each address → in_ready=0 while held, addr_out stable, identical sequence.
- 12 columns of one nonzero each → 11 addresses 1..11, 12th dropped, err=1, terminator still emitted.
- 256 nonzero values in one column → addr_out=255, err=1.
- Assert reset (0) while address 2 is pending → next cycle addr_valid=0, cnt=0. A fresh matrix encodes correctly.
